pid_wb_master: RTL and testbench

PID_WB_MASTER -- requirements
Module: pid_wb_master

---
 rtl/pid_wb_master.sv | 187 ++++++++++++++++++
 tb/tb_pid_wb_master.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_wb_master.sv
// Wishbone classic master that drives a PID slave: loads gains and setpoint,
// runs one control step (write pv, read un/of) or clears the controller state.
module pid_wb_master #(
  parameter int WB_NB   = 32,
  parameter int ADR_NB  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg,
  input  logic [15:0]       i_kp,
  input  logic [15:0]       i_ki,
  input  logic [15:0]       i_kd,
  input  logic [15:0]       i_sp,
  input  logic              i_start,
  input  logic [15:0]       i_pv,
  input  logic              i_clr,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADR_NB-1:0] o_wb_adr,
  output logic [WB_NB-1:0]  o_wb_data,
  input  logic              i_wb_ack,
  input  logic [WB_NB-1:0]  i_wb_data,
  output logic [31:0]       o_un,
  output logic [4:0]        o_of,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] Q_CFG = 2'd0;
  localparam logic [1:0] Q_RUN = 2'd1;
  localparam logic [1:0] Q_CLR = 2'd2;

  localparam logic [8:0] W_TO = 9'(TIMEOUT);

  logic [1:0]        r_state;
  logic [1:0]        r_seq;
  logic [1:0]        r_idx;
  logic [7:0]        r_wait;
  logic [15:0]       r_ki;
  logic [15:0]       r_kd;
  logic [15:0]       r_sp;
  logic              r_cyc;
  logic              r_we;
  logic [ADR_NB-1:0] r_adr;
  logic [WB_NB-1:0]  r_data;
  logic [31:0]       r_un;
  logic [4:0]        r_of;
  logic              r_err;

  logic              w_idle;
  logic              w_any;
  logic [1:0]        w_nseq;
  logic [1:0]        w_nidx;
  logic              w_last;
  logic [7:0]        w_adr8;
  logic              w_we;
  logic [15:0]       w_val;
  logic [8:0]        w_wait_nx;
  logic              w_to;

  assign w_idle    = (r_state == S_IDLE);
  assign w_any     = i_clr | i_cfg | i_start;
  assign w_nidx    = w_idle ? 2'd0 : r_idx + 2'd1;
  assign w_wait_nx = {1'b0, r_wait} + 9'd1;
  assign w_to      = (w_wait_nx >= W_TO);

  assign w_last = (r_seq == Q_CLR) ||
                  (r_seq == Q_CFG && r_idx == 2'd3) ||
                  (r_seq == Q_RUN && r_idx == 2'd2);

  always_comb begin
    w_nseq = r_seq;
    if (w_idle) begin
      if (i_clr)      w_nseq = Q_CLR;
      else if (i_cfg) w_nseq = Q_CFG;
      else            w_nseq = Q_RUN;
    end
  end

  // First access of a sequence takes its operand straight from the inputs
  always_comb begin
    w_adr8 = 8'h00;
    w_we   = 1'b1;
    w_val  = 16'h0000;
    case ({w_nseq, w_nidx})
      {Q_CFG, 2'd0}: begin w_adr8 = 8'h00; w_val = i_kp; end
      {Q_CFG, 2'd1}: begin w_adr8 = 8'h04; w_val = r_ki; end
      {Q_CFG, 2'd2}: begin w_adr8 = 8'h08; w_val = r_kd; end
      {Q_CFG, 2'd3}: begin w_adr8 = 8'h0C; w_val = r_sp; end
      {Q_RUN, 2'd0}: begin w_adr8 = 8'h10; w_val = i_pv; end
      {Q_RUN, 2'd1}: begin w_adr8 = 8'h20; w_we = 1'b0; end
      {Q_RUN, 2'd2}: begin w_adr8 = 8'h28; w_we = 1'b0; end
      {Q_CLR, 2'd0}: begin w_adr8 = 8'h2C; end
      default:       begin w_adr8 = 8'h00; end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_seq   <= Q_CFG;
      r_idx   <= 2'd0;
      r_wait  <= 8'd0;
      r_ki    <= 16'd0;
      r_kd    <= 16'd0;
      r_sp    <= 16'd0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_data  <= '0;
      r_un    <= 32'd0;
      r_of    <= 5'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_REQ;
            r_seq   <= w_nseq;
            r_idx   <= 2'd0;
            r_wait  <= 8'd0;
            r_err   <= 1'b0;
            r_cyc   <= 1'b1;
            r_we    <= w_we;
            r_adr   <= ADR_NB'(w_adr8);
            r_data  <= {{(WB_NB-16){w_val[15]}}, w_val};
            if (!i_clr && i_cfg) begin
              r_ki <= i_ki;
              r_kd <= i_kd;
              r_sp <= i_sp;
            end
          end
        end
        S_REQ: begin
          if (i_wb_ack) begin
            r_cyc   <= 1'b0;
            r_state <= S_GAP;
            if (r_seq == Q_RUN && r_idx == 2'd1) r_un <= 32'(i_wb_data);
            if (r_seq == Q_RUN && r_idx == 2'd2) r_of <= i_wb_data[4:0];
          end else if (w_to) begin
            r_cyc   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait <= w_wait_nx[7:0];
          end
        end
        // Address/data stay put here: the slave keys its update on them
        S_GAP: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_REQ;
            r_idx   <= w_nidx;
            r_wait  <= 8'd0;
            r_cyc   <= 1'b1;
            r_we    <= w_we;
            r_adr   <= ADR_NB'(w_adr8);
            r_data  <= {{(WB_NB-16){w_val[15]}}, w_val};
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_cyc;
  assign o_wb_we   = r_we;
  assign o_wb_adr  = r_adr;
  assign o_wb_data = r_data;
  assign o_un      = r_un;
  assign o_of      = r_of;
  assign o_busy    = !w_idle;
  assign o_done    = (r_state == S_DONE);
  assign o_err     = r_err;

endmodule

// File: tb/tb_pid_wb_master.sv
// Directed bench for pid_wb_master with a PID slave model and a
// scoreboard of expected bus transactions.
module tb_pid_wb_master;

  logic        clk;
  logic        rst_n;
  logic        i_cfg, i_start, i_clr;
  logic [15:0] i_kp, i_ki, i_kd, i_sp, i_pv;
  logic        cyc, stb, we;
  logic [15:0] adr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] o_un;
  logic [4:0]  o_of;
  logic        o_busy, o_done, o_err;

  pid_wb_master #(.WB_NB(32), .ADR_NB(16), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg(i_cfg), .i_kp(i_kp), .i_ki(i_ki), .i_kd(i_kd), .i_sp(i_sp),
    .i_start(i_start), .i_pv(i_pv), .i_clr(i_clr),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we),
    .o_wb_adr(adr), .o_wb_data(wdata),
    .i_wb_ack(ack), .i_wb_data(rdata),
    .o_un(o_un), .o_of(o_of),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  typedef struct {
    logic [15:0] adr;
    logic        we;
    logic [31:0] data;
    logic        chkd;
  } tx_t;
  tx_t sb[$];

  task automatic exp_tx(input logic [15:0] a, input logic w,
                        input logic [31:0] d, input logic c);
    tx_t e;
    e.adr = a; e.we = w; e.data = d; e.chkd = c;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Slave: fixed ack latency, optional never-ack, un read stalls while busy
  int        lat = 2;
  logic      never_ack = 1'b0;
  int        cnt;
  int        s_kp, s_ki, s_kd, s_sp, s_sig, s_ep, s_un, s_pend;
  int        s_busy;

  always @(posedge clk) begin : slave
    int e;
    logic stall;
    if (!rst_n) begin
      ack <= 1'b0; cnt <= 0; rdata <= 32'd0; s_busy <= 0;
    end else begin
      if (s_busy != 0) begin
        s_busy <= s_busy - 1;
        if (s_busy == 1) s_un <= s_pend;
      end
      if (ack) begin
        ack <= 1'b0; cnt <= 0;
        if (cyc && stb && we) begin
          case (adr)
            16'h00: s_kp <= int'($signed(wdata));
            16'h04: s_ki <= int'($signed(wdata));
            16'h08: s_kd <= int'($signed(wdata));
            16'h0C: s_sp <= int'($signed(wdata));
            16'h10: begin
              e = s_sp - int'($signed(wdata));
              s_sig <= s_sig + e;
              s_pend <= s_kp * e + s_ki * (s_sig + e) + s_kd * (e - s_ep);
              s_ep <= e;
              s_busy <= 5;
            end
            16'h2C: begin s_sig <= 0; s_ep <= 0; s_un <= 0; end
            default: ;
          endcase
        end
      end else if (cyc && stb) begin
        stall = never_ack || (adr == 16'h20 && s_busy != 0);
        if (!stall && cnt + 1 >= lat) begin
          ack <= 1'b1;
          rdata <= (adr == 16'h20) ? s_un : 32'd0;
        end
        cnt <= cnt + 1;
      end else begin
        cnt <= 0;
      end
    end
  end

  // Monitor: scoreboard on every ack, gap/hold check on the following cycle
  int          tx_cnt = 0;
  int          done_cnt = 0;
  logic        gap_pend = 1'b0;
  logic [15:0] gap_adr;

  always @(negedge clk) begin : mon
    tx_t e;
    if (gap_pend) begin
      chk("gap_stb", {31'd0, stb}, 32'd0);
      chk("gap_cyc", {31'd0, cyc}, 32'd0);
      chk("gap_adr", {16'd0, adr}, {16'd0, gap_adr});
    end
    gap_pend <= 1'b0;
    if (rst_n && cyc && stb && ack) begin
      tx_cnt <= tx_cnt + 1;
      gap_pend <= 1'b1;
      gap_adr <= adr;
      chk("sb_avail", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("tx_adr", {16'd0, adr}, {16'd0, e.adr});
        chk("tx_we", {31'd0, we}, {31'd0, e.we});
        if (e.chkd) chk("tx_data", wdata, e.data);
      end
    end
    if (o_done) done_cnt <= done_cnt + 1;
  end

  task automatic pulse(input logic c, input logic f, input logic s);
    @(negedge clk);
    i_clr = c; i_cfg = f; i_start = s;
    @(negedge clk);
    i_clr = 1'b0; i_cfg = 1'b0; i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(tag, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cyc"},  {31'd0, cyc}, 32'd0);
    chk({tag, "_stb"},  {31'd0, stb}, 32'd0);
    chk({tag, "_we"},   {31'd0, we}, 32'd0);
    chk({tag, "_adr"},  {16'd0, adr}, 32'd0);
    chk({tag, "_data"}, wdata, 32'd0);
    chk({tag, "_un"},   o_un, 32'd0);
    chk({tag, "_of"},   {27'd0, o_of}, 32'd0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd0);
    chk({tag, "_err"},  {31'd0, o_err}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t0, n, nstb;
    rst_n = 1'b0;
    i_cfg = 1'b0; i_start = 1'b0; i_clr = 1'b0;
    i_kp = 16'd0; i_ki = 16'd0; i_kd = 16'd0; i_sp = 16'd0; i_pv = 16'd0;
    s_kp = 0; s_ki = 0; s_kd = 0; s_sp = 0;
    s_sig = 0; s_ep = 0; s_un = 0; s_pend = 0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    // Configuration: kp=3 ki=1 kd=2 sp=100
    d0 = done_cnt; t0 = tx_cnt;
    i_kp = 16'd3; i_ki = 16'd1; i_kd = 16'd2; i_sp = 16'd100;
    exp_tx(16'h00, 1'b1, sx(16'd3), 1'b1);
    exp_tx(16'h04, 1'b1, sx(16'd1), 1'b1);
    exp_tx(16'h08, 1'b1, sx(16'd2), 1'b1);
    exp_tx(16'h0C, 1'b1, 32'h64, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle("cfg_idle");
    chk("cfg_done", done_cnt - d0, 32'd1);
    chk("cfg_txs", tx_cnt - t0, 32'd4);
    chk("cfg_err", {31'd0, o_err}, 32'd0);

    // Control step with pv = -10; un read is stalled by the slave
    d0 = done_cnt;
    i_pv = 16'hFFF6;
    exp_tx(16'h10, 1'b1, 32'hFFFFFFF6, 1'b1);
    exp_tx(16'h20, 1'b0, 32'd0, 1'b0);
    exp_tx(16'h28, 1'b0, 32'd0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    wait_idle("run_idle");
    chk("run_un", o_un, 32'd660);
    chk("run_of", {27'd0, o_of}, 32'd0);
    chk("run_done", done_cnt - d0, 32'd1);

    // Clear and start together: clear wins, start is dropped
    d0 = done_cnt; t0 = tx_cnt;
    exp_tx(16'h2C, 1'b1, 32'd0, 1'b1);
    pulse(1'b1, 1'b0, 1'b1);
    wait_idle("clr_idle");
    chk("clr_txs", tx_cnt - t0, 32'd1);
    chk("clr_un", o_un, 32'd660);
    chk("clr_done", done_cnt - d0, 32'd1);

    // Slave never acks: abort after TIMEOUT cycles in REQ
    never_ack = 1'b1;
    d0 = done_cnt; t0 = tx_cnt;
    i_pv = 16'd5;
    pulse(1'b0, 1'b0, 1'b1);
    n = 0; nstb = 0;
    while (o_busy && n < 50) begin
      if (stb) nstb++;
      @(negedge clk);
      n++;
    end
    #1;
    chk("to_idle", {31'd0, o_busy}, 32'd0);
    chk("to_stb_cycles", nstb, 32'd8);
    chk("to_err", {31'd0, o_err}, 32'd1);
    chk("to_done", done_cnt - d0, 32'd0);
    chk("to_txs", tx_cnt - t0, 32'd0);
    chk("to_un", o_un, 32'd660);
    never_ack = 1'b0;

    // Next start clears the error; slave state was cleared, so e=10
    d0 = done_cnt;
    i_pv = 16'd90;
    exp_tx(16'h10, 1'b1, 32'd90, 1'b1);
    exp_tx(16'h20, 1'b0, 32'd0, 1'b0);
    exp_tx(16'h28, 1'b0, 32'd0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("rerun_err_clr", {31'd0, o_err}, 32'd0);
    chk("rerun_busy", {31'd0, o_busy}, 32'd1);
    wait_idle("rerun_idle");
    chk("rerun_un", o_un, 32'd60);
    chk("rerun_done", done_cnt - d0, 32'd1);

    // Reset during the second configuration write
    t0 = tx_cnt;
    i_kp = 16'd7;
    exp_tx(16'h00, 1'b1, 32'd7, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    n = 0;
    while (!(tx_cnt == t0 + 1 && stb) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach", {31'd0, stb}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_txs", tx_cnt - t0, 32'd1);
    chk("mid_sb", sb.size(), 32'd0);

    // Replay the full configuration after reset
    d0 = done_cnt; t0 = tx_cnt;
    exp_tx(16'h00, 1'b1, 32'd7, 1'b1);
    exp_tx(16'h04, 1'b1, 32'd1, 1'b1);
    exp_tx(16'h08, 1'b1, 32'd2, 1'b1);
    exp_tx(16'h0C, 1'b1, 32'h64, 1'b1);
    pulse(1'b0, 1'b1, 1'b0);
    wait_idle("replay_idle");
    chk("replay_txs", tx_cnt - t0, 32'd4);
    chk("replay_done", done_cnt - d0, 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
